// File: rtl/lm80c_ps2_matrix.sv
// LM80C keyboard producer: PS/2 set-2 receiver plus scancode decoder that maintains
// the 8x8 active-low key matrix scanned by the YM2149 port logic.
module lm80c_ps2_matrix #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 32000
) (
  input  logic            sys_clock,
  input  logic            RESET,
  input  logic            ps2_clk,
  input  logic            ps2_data,
  output logic [7:0][7:0] KM,
  output logic            key_event,
  output logic            rx_error
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_BRK, S_EXT, S_EXTBRK, S_SKIP} dec_state_t;

  logic [1:0]    clk_sync_r;
  logic [1:0]    data_sync_r;
  logic          clk_filt_r;
  logic          clk_filt_d_r;
  logic [FW-1:0] filt_cnt_r;
  logic [3:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic          parity_r;
  logic [TW-1:0] timer_r;
  dec_state_t    state_r;
  logic [2:0]    skip_r;

  logic       strobe_s;
  logic       data_s;
  logic       rx_valid_s;
  logic       ext_s;
  logic [6:0] map_s;
  logic       hit_s;
  logic [2:0] row_s;
  logic [2:0] col_s;

  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  function automatic logic parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  // {ext, code} -> {hit, row, col} from the LM80C keyboard table.
  function automatic logic [6:0] key_map(input logic ext, input logic [7:0] code);
    logic [6:0] m;
    case ({ext, code})
      9'h016: m = {1'b1, 3'd0, 3'd0};
      9'h01E: m = {1'b1, 3'd0, 3'd1};
      9'h026: m = {1'b1, 3'd0, 3'd2};
      9'h175: m = {1'b1, 3'd0, 3'd3};
      9'h025: m = {1'b1, 3'd0, 3'd4};
      9'h02E: m = {1'b1, 3'd0, 3'd5};
      9'h036: m = {1'b1, 3'd0, 3'd6};
      9'h03D: m = {1'b1, 3'd0, 3'd7};
      9'h015: m = {1'b1, 3'd1, 3'd0};
      9'h01D: m = {1'b1, 3'd1, 3'd1};
      9'h01C: m = {1'b1, 3'd1, 3'd2};
      9'h01B: m = {1'b1, 3'd1, 3'd3};
      9'h024: m = {1'b1, 3'd1, 3'd4};
      9'h02D: m = {1'b1, 3'd1, 3'd5};
      9'h023: m = {1'b1, 3'd1, 3'd6};
      9'h02B: m = {1'b1, 3'd1, 3'd7};
      9'h02C: m = {1'b1, 3'd2, 3'd0};
      9'h035: m = {1'b1, 3'd2, 3'd1};
      9'h034: m = {1'b1, 3'd2, 3'd2};
      9'h033: m = {1'b1, 3'd2, 3'd3};
      9'h03C: m = {1'b1, 3'd2, 3'd4};
      9'h043: m = {1'b1, 3'd2, 3'd5};
      9'h03B: m = {1'b1, 3'd2, 3'd6};
      9'h042: m = {1'b1, 3'd2, 3'd7};
      9'h044: m = {1'b1, 3'd3, 3'd0};
      9'h04D: m = {1'b1, 3'd3, 3'd1};
      9'h04B: m = {1'b1, 3'd3, 3'd2};
      9'h04C: m = {1'b1, 3'd3, 3'd3};
      9'h03E: m = {1'b1, 3'd3, 3'd4};
      9'h046: m = {1'b1, 3'd3, 3'd5};
      9'h045: m = {1'b1, 3'd3, 3'd6};
      9'h04E: m = {1'b1, 3'd3, 3'd7};
      9'h01A: m = {1'b1, 3'd4, 3'd0};
      9'h022: m = {1'b1, 3'd4, 3'd1};
      9'h021: m = {1'b1, 3'd4, 3'd2};
      9'h02A: m = {1'b1, 3'd4, 3'd3};
      9'h032: m = {1'b1, 3'd4, 3'd4};
      9'h031: m = {1'b1, 3'd4, 3'd5};
      9'h03A: m = {1'b1, 3'd4, 3'd6};
      9'h041: m = {1'b1, 3'd4, 3'd7};
      9'h049: m = {1'b1, 3'd5, 3'd0};
      9'h04A: m = {1'b1, 3'd5, 3'd1};
      9'h055: m = {1'b1, 3'd5, 3'd2};
      9'h052: m = {1'b1, 3'd5, 3'd3};
      9'h054: m = {1'b1, 3'd5, 3'd4};
      9'h05B: m = {1'b1, 3'd5, 3'd5};
      9'h05D: m = {1'b1, 3'd5, 3'd6};
      9'h066: m = {1'b1, 3'd5, 3'd7};
      9'h012: m = {1'b1, 3'd6, 3'd0};
      9'h059: m = {1'b1, 3'd6, 3'd1};
      9'h014: m = {1'b1, 3'd6, 3'd2};
      9'h011: m = {1'b1, 3'd6, 3'd3};
      9'h00D: m = {1'b1, 3'd6, 3'd4};
      9'h076: m = {1'b1, 3'd6, 3'd5};
      9'h005: m = {1'b1, 3'd6, 3'd6};
      9'h006: m = {1'b1, 3'd6, 3'd7};
      9'h05A: m = {1'b1, 3'd7, 3'd0};
      9'h172: m = {1'b1, 3'd7, 3'd1};
      9'h16B: m = {1'b1, 3'd7, 3'd2};
      9'h174: m = {1'b1, 3'd7, 3'd3};
      9'h029: m = {1'b1, 3'd7, 3'd4};
      9'h004: m = {1'b1, 3'd7, 3'd5};
      9'h00C: m = {1'b1, 3'd7, 3'd6};
      9'h058: m = {1'b1, 3'd7, 3'd7};
      default: m = 7'd0;
    endcase
    return m;
  endfunction

  // Bit strobe and frame-check terms derived from registered state.
  always_comb begin
    strobe_s   = clk_filt_d_r & ~clk_filt_r;
    data_s     = data_sync_r[1];
    rx_valid_s = strobe_s && (bit_cnt_r == 4'd10) && data_s && parity_ok(shift_r, parity_r);
    ext_s      = (state_r == S_EXT) || (state_r == S_EXTBRK);
    map_s      = key_map(ext_s, shift_r);
    hit_s      = map_s[6];
    row_s      = map_s[5:3];
    col_s      = map_s[2:0];
  end

  // Two-stage synchronisers and the ps2_clk glitch filter.
  always_ff @(posedge sys_clock or posedge RESET) begin
    if (RESET) begin
      clk_sync_r   <= 2'b11;
      data_sync_r  <= 2'b11;
      clk_filt_r   <= 1'b1;
      clk_filt_d_r <= 1'b1;
      filt_cnt_r   <= '0;
    end else begin
      clk_sync_r   <= {clk_sync_r[0], ps2_clk};
      data_sync_r  <= {data_sync_r[0], ps2_data};
      clk_filt_d_r <= clk_filt_r;
      if (clk_sync_r[1] == clk_filt_r) begin
        filt_cnt_r <= '0;
      end else if (filt_cnt_r == FW'(FILTER_LEN - 1)) begin
        clk_filt_r <= ~clk_filt_r;
        filt_cnt_r <= '0;
      end else begin
        filt_cnt_r <= filt_cnt_r + 1'b1;
      end
    end
  end

  // Frame receiver: start, eight data bits LSB first, parity, stop; plus abort timer.
  always_ff @(posedge sys_clock or posedge RESET) begin
    if (RESET) begin
      bit_cnt_r <= 4'd0;
      shift_r   <= 8'h00;
      parity_r  <= 1'b0;
      timer_r   <= '0;
      rx_error  <= 1'b0;
    end else begin
      rx_error <= 1'b0;
      if (strobe_s) begin
        timer_r <= '0;
        case (bit_cnt_r)
          4'd0: begin
            if (!data_s) bit_cnt_r <= 4'd1;
            else         rx_error  <= 1'b1;
          end
          4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
            shift_r   <= {data_s, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 4'd1;
          end
          4'd9: begin
            parity_r  <= data_s;
            bit_cnt_r <= 4'd10;
          end
          4'd10: begin
            bit_cnt_r <= 4'd0;
            if (!rx_valid_s) rx_error <= 1'b1;
          end
          default: bit_cnt_r <= 4'd0;
        endcase
      end else if (bit_cnt_r != 4'd0) begin
        if (timer_r == TW'(TIMEOUT_CYCLES - 1)) begin
          timer_r   <= '0;
          bit_cnt_r <= 4'd0;
          rx_error  <= 1'b1;
        end else begin
          timer_r <= timer_r + 1'b1;
        end
      end else begin
        timer_r <= '0;
      end
    end
  end

  // Scancode decoder and key matrix; the matrix bit is written on the stop-bit strobe.
  always_ff @(posedge sys_clock or posedge RESET) begin
    if (RESET) begin
      state_r   <= S_IDLE;
      skip_r    <= 3'd0;
      KM        <= '1;
      key_event <= 1'b0;
    end else begin
      key_event <= 1'b0;
      if (rx_valid_s) begin
        case (state_r)
          S_IDLE: begin
            if (shift_r == 8'hF0) begin
              state_r <= S_BRK;
            end else if (shift_r == 8'hE0) begin
              state_r <= S_EXT;
            end else if (shift_r == 8'hE1) begin
              state_r <= S_SKIP;
              skip_r  <= 3'd7;
            end else if (shift_r == 8'hAA) begin
              if (KM != '1) key_event <= 1'b1;
              KM <= '1;
            end else if (hit_s && KM[row_s][col_s]) begin
              KM[row_s][col_s] <= 1'b0;
              key_event        <= 1'b1;
            end
          end
          S_BRK, S_EXTBRK: begin
            if (hit_s && !KM[row_s][col_s]) begin
              KM[row_s][col_s] <= 1'b1;
              key_event        <= 1'b1;
            end
            state_r <= S_IDLE;
          end
          S_EXT: begin
            if (shift_r == 8'hF0) begin
              state_r <= S_EXTBRK;
            end else begin
              // E0 12 / E0 59 are fake shifts emitted around extended keys.
              if (shift_r != 8'h12 && shift_r != 8'h59 && hit_s && KM[row_s][col_s]) begin
                KM[row_s][col_s] <= 1'b0;
                key_event        <= 1'b1;
              end
              state_r <= S_IDLE;
            end
          end
          S_SKIP: begin
            skip_r <= skip_r - 3'd1;
            if (skip_r == 3'd1) state_r <= S_IDLE;
          end
          default: state_r <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lm80c_ps2_matrix.sv
// Self-checking bench for lm80c_ps2_matrix: directed vector table, hand sequences
// for timeout/glitch/reset, and randomized key traffic against a key-level model.
module tb_lm80c_ps2_matrix;

  localparam int TO = 2000;
  localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;

  logic            sys_clock = 1'b0;
  logic            RESET;
  logic            ps2_clk;
  logic            ps2_data;
  logic [7:0][7:0] KM;
  logic            key_event;
  logic            rx_error;
  logic [63:0]     km_flat;

  int checks  = 0;
  int errors  = 0;
  int ev_cnt  = 0;
  int err_cnt = 0;

  typedef struct {
    logic [7:0]  code;
    logic        bad;
    logic [63:0] km;
    int          ev;
    int          er;
  } vec_t;
  vec_t tbl[25];

  logic [7:0] mk_code[5] = '{8'h1C, 8'h29, 8'h12, 8'h5A, 8'h75};
  bit         mk_ext [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  int         mk_row [5] = '{1, 7, 6, 7, 0};
  int         mk_col [5] = '{2, 4, 0, 0, 3};

  lm80c_ps2_matrix #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
    .sys_clock(sys_clock),
    .RESET    (RESET),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .KM       (KM),
    .key_event(key_event),
    .rx_error (rx_error)
  );

  always #5 sys_clock = ~sys_clock;
  assign km_flat = KM;

  always @(negedge sys_clock) begin
    if (key_event) ev_cnt++;
    if (rx_error)  err_cnt++;
  end

  function automatic logic [63:0] kb(input int r, input int c);
    return 64'd1 << (r * 8 + c);
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge sys_clock);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      wait_cycles(4);
      ps2_clk = 1'b0;
      wait_cycles(16);
      ps2_clk = 1'b1;
      wait_cycles(12);
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip_par);
    logic p;
    p = (~^b) ^ flip_par;
    send_bits({1'b1, p, b, 1'b0}, 11);
    wait_cycles(20);
  endtask

  task automatic send_key(input int k, input bit rel);
    if (mk_ext[k]) send_frame(8'hE0, 1'b0);
    if (rel)       send_frame(8'hF0, 1'b0);
    send_frame(mk_code[k], 1'b0);
  endtask

  initial begin
    logic [63:0] a_m, up_m, sh_m, sp_m, km_m, pos;
    int e0, r0, act, k, exp_ev, exp_er;

    a_m  = kb(1, 2);
    up_m = kb(0, 3);
    sh_m = kb(6, 0);
    sp_m = kb(7, 4);
    tbl[0]  = '{8'h1C, 1'b0, ~a_m, 1, 0};
    tbl[1]  = '{8'hF0, 1'b0, ~a_m, 0, 0};
    tbl[2]  = '{8'h1C, 1'b0, ALL, 1, 0};
    tbl[3]  = '{8'hE0, 1'b0, ALL, 0, 0};
    tbl[4]  = '{8'h75, 1'b0, ~up_m, 1, 0};
    tbl[5]  = '{8'hE0, 1'b0, ~up_m, 0, 0};
    tbl[6]  = '{8'hF0, 1'b0, ~up_m, 0, 0};
    tbl[7]  = '{8'h75, 1'b0, ALL, 1, 0};
    tbl[8]  = '{8'hE0, 1'b0, ALL, 0, 0};
    tbl[9]  = '{8'h12, 1'b0, ALL, 0, 0};
    tbl[10] = '{8'h12, 1'b0, ~sh_m, 1, 0};
    tbl[11] = '{8'h1C, 1'b0, ~(sh_m | a_m), 1, 0};
    tbl[12] = '{8'h1C, 1'b0, ~(sh_m | a_m), 0, 0};
    tbl[13] = '{8'hAA, 1'b0, ALL, 1, 0};
    tbl[14] = '{8'h1C, 1'b1, ALL, 0, 1};
    tbl[15] = '{8'h29, 1'b0, ~sp_m, 1, 0};
    tbl[16] = '{8'hE1, 1'b0, ~sp_m, 0, 0};
    tbl[17] = '{8'h14, 1'b0, ~sp_m, 0, 0};
    tbl[18] = '{8'h77, 1'b0, ~sp_m, 0, 0};
    tbl[19] = '{8'hE1, 1'b0, ~sp_m, 0, 0};
    tbl[20] = '{8'hF0, 1'b0, ~sp_m, 0, 0};
    tbl[21] = '{8'h14, 1'b0, ~sp_m, 0, 0};
    tbl[22] = '{8'hF0, 1'b0, ~sp_m, 0, 0};
    tbl[23] = '{8'h77, 1'b0, ~sp_m, 0, 0};
    tbl[24] = '{8'h1C, 1'b0, ~(sp_m | a_m), 1, 0};

    // Reset state.
    RESET = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    wait_cycles(5);
    RESET = 1'b0;
    wait_cycles(50);
    chk("reset_km", km_flat, ALL);
    chk("reset_key_event", {63'd0, key_event}, 64'd0);
    chk("reset_events_seen", 64'(ev_cnt), 64'd0);
    chk("reset_rx_error", 64'(err_cnt), 64'd0);

    // Directed vector table.
    for (int i = 0; i < 25; i++) begin
      e0 = ev_cnt; r0 = err_cnt;
      send_frame(tbl[i].code, tbl[i].bad);
      chk($sformatf("tbl%0d_km", i), km_flat, tbl[i].km);
      chk($sformatf("tbl%0d_events", i), 64'(ev_cnt - e0), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d_errors", i), 64'(err_cnt - r0), 64'(tbl[i].er));
    end

    // Partial frame followed by a long idle aborts with an error.
    send_frame(8'hAA, 1'b0);
    e0 = ev_cnt; r0 = err_cnt;
    send_bits(11'b000_0000_0000, 5);
    wait_cycles(TO + 60);
    chk("timeout_error", 64'(err_cnt - r0), 64'd1);
    send_frame(8'h5A, 1'b0);
    chk("timeout_recover_km", km_flat, ~kb(7, 0));
    chk("timeout_recover_events", 64'(ev_cnt - e0), 64'd1);

    // Short ps2_clk glitch must not be taken as a bit.
    r0 = err_cnt; e0 = ev_cnt;
    ps2_data = 1'b0;
    wait_cycles(4);
    ps2_clk = 1'b0;
    wait_cycles(5);
    ps2_clk = 1'b1;
    wait_cycles(4);
    ps2_data = 1'b1;
    wait_cycles(40);
    chk("glitch_no_error", 64'(err_cnt - r0), 64'd0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h5A, 1'b0);
    chk("glitch_after_km", km_flat, ALL);
    chk("glitch_after_events", 64'(ev_cnt - e0), 64'd1);
    chk("glitch_after_errors", 64'(err_cnt - r0), 64'd0);

    // Randomized key traffic against a key-level matrix model.
    km_m = ALL;
    for (int n = 0; n < 40; n++) begin
      e0 = ev_cnt; r0 = err_cnt;
      act = $urandom_range(0, 9);
      k = $urandom_range(0, 4);
      pos = kb(mk_row[k], mk_col[k]);
      exp_ev = 0; exp_er = 0;
      if (act <= 3) begin
        send_key(k, 1'b0);
        exp_ev = ((km_m & pos) != 64'd0) ? 1 : 0;
        km_m = km_m & ~pos;
      end else if (act <= 6) begin
        send_key(k, 1'b1);
        exp_ev = ((km_m & pos) == 64'd0) ? 1 : 0;
        km_m = km_m | pos;
      end else if (act == 7) begin
        send_frame(8'hAA, 1'b0);
        exp_ev = (km_m != ALL) ? 1 : 0;
        km_m = ALL;
      end else if (act == 8) begin
        send_frame(8'h0E, 1'b0);
      end else begin
        send_frame(mk_code[k] == 8'h75 ? 8'h1C : mk_code[k], 1'b1);
        exp_er = 1;
      end
      chk($sformatf("rnd%0d_km", n), km_flat, km_m);
      chk($sformatf("rnd%0d_events", n), 64'(ev_cnt - e0), 64'(exp_ev));
      chk($sformatf("rnd%0d_errors", n), 64'(err_cnt - r0), 64'(exp_er));
    end

    // Reset mid-frame discards both the frame and a pending break prefix.
    send_frame(8'h1C, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_bits(11'b000_0000_0000, 5);
    RESET = 1'b1;
    wait_cycles(5);
    RESET = 1'b0;
    wait_cycles(20);
    chk("midreset_km", km_flat, ALL);
    e0 = ev_cnt; r0 = err_cnt;
    send_frame(8'h1C, 1'b0);
    chk("midreset_press_km", km_flat, ~kb(1, 2));
    chk("midreset_press_events", 64'(ev_cnt - e0), 64'd1);
    chk("midreset_press_errors", 64'(err_cnt - r0), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
